// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, debug-loadable instruction memory
// and next-PC selection for the 5-stage MIPS pipeline.
module fetch_stage #(
  parameter int unsigned               NB_DATA          = 32,
  parameter int unsigned               NB_ADDR          = 8,
  parameter logic [NB_DATA-1:0]        HALT_INSTRUCTION = 32'hFFFF_FFFF
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_valid,
  input  logic               i_start,
  input  logic               i_execution_mode,
  input  logic               i_step,
  input  logic               i_stall,
  input  logic               i_jump,
  input  logic [NB_DATA-1:0] i_pc_jump,
  input  logic               i_branch_taken,
  input  logic [NB_DATA-1:0] i_pc_branch,
  input  logic               i_mem_write_enable,
  input  logic [NB_ADDR-1:0] i_mem_write_addr,
  input  logic [NB_DATA-1:0] i_mem_write_data,
  output logic [NB_DATA-1:0] o_instruction,
  output logic [NB_DATA-1:0] o_pc_next,
  output logic [NB_DATA-1:0] o_pc,
  output logic               o_halt,
  output logic               o_running
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    HALTED
  } state_t;

  state_t             state_q, state_d;
  logic [NB_DATA-1:0] pc_q, pc_d;
  logic [NB_DATA-1:0] pc_plus4;
  logic               advance;
  logic               halting;

  logic [NB_DATA-1:0] mem [2**NB_ADDR];

  assign pc_plus4      = pc_q + NB_DATA'(4);
  assign o_instruction = mem[pc_q[NB_ADDR+1:2]];
  assign o_pc_next     = pc_plus4;
  assign o_pc          = pc_q;
  assign o_halt        = (o_instruction == HALT_INSTRUCTION);
  assign o_running     = (state_q == RUN);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    advance = i_valid && (state_q == RUN) && (!i_execution_mode || i_step);
    halting = advance && o_halt && !i_stall && !i_jump && !i_branch_taken;

    case (state_q)
      IDLE:    if (i_valid && i_start) state_d = RUN;
      RUN:     if (halting) state_d = HALTED;
      default: state_d = state_q;
    endcase

    // A halting advance keeps PC on the halt word instead of stepping past it.
    if (advance) begin
      if (i_branch_taken)  pc_d = i_pc_branch;
      else if (i_jump)     pc_d = i_pc_jump;
      else if (i_stall)    pc_d = pc_q;
      else if (!halting)   pc_d = pc_plus4;
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q <= IDLE;
      pc_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  // Program memory is deliberately not reset so a loaded program survives.
  always_ff @(posedge i_clock) begin
    if (i_valid && i_mem_write_enable && (state_q == IDLE))
      mem[i_mem_write_addr] <= i_mem_write_data;
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage.
module tb_fetch_stage;

  logic        i_clock;
  logic        i_reset;
  logic        i_valid;
  logic        i_start;
  logic        i_execution_mode;
  logic        i_step;
  logic        i_stall;
  logic        i_jump;
  logic [31:0] i_pc_jump;
  logic        i_branch_taken;
  logic [31:0] i_pc_branch;
  logic        i_mem_write_enable;
  logic [7:0]  i_mem_write_addr;
  logic [31:0] i_mem_write_data;
  logic [31:0] o_instruction;
  logic [31:0] o_pc_next;
  logic [31:0] o_pc;
  logic        o_halt;
  logic        o_running;

  int checks = 0;
  int errors = 0;

  fetch_stage #(
    .NB_DATA(32),
    .NB_ADDR(8),
    .HALT_INSTRUCTION(32'hFFFF_FFFF)
  ) dut (
    .i_clock(i_clock),
    .i_reset(i_reset),
    .i_valid(i_valid),
    .i_start(i_start),
    .i_execution_mode(i_execution_mode),
    .i_step(i_step),
    .i_stall(i_stall),
    .i_jump(i_jump),
    .i_pc_jump(i_pc_jump),
    .i_branch_taken(i_branch_taken),
    .i_pc_branch(i_pc_branch),
    .i_mem_write_enable(i_mem_write_enable),
    .i_mem_write_addr(i_mem_write_addr),
    .i_mem_write_data(i_mem_write_data),
    .o_instruction(o_instruction),
    .o_pc_next(o_pc_next),
    .o_pc(o_pc),
    .o_halt(o_halt),
    .o_running(o_running)
  );

  initial i_clock = 1'b0;
  always #5 i_clock = ~i_clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge i_clock);
    #1;
  endtask

  task automatic do_reset();
    i_reset = 1'b1;
    tick();
    i_reset = 1'b0;
  endtask

  task automatic load_word(input logic [7:0] addr, input logic [31:0] data);
    i_mem_write_enable = 1'b1;
    i_mem_write_addr   = addr;
    i_mem_write_data   = data;
    tick();
    i_mem_write_enable = 1'b0;
  endtask

  task automatic pulse_start();
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
  endtask

  task automatic test_reset();
    i_valid = 1'b1;
    do_reset();
    checks++; if (o_pc !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h expected %h", o_pc, 32'h0); end
    checks++; if (o_pc_next !== 32'h4) begin errors++; $display("FAIL reset_pc_next: got %h expected %h", o_pc_next, 32'h4); end
    checks++; if (o_running !== 1'b0) begin errors++; $display("FAIL reset_running: got %b expected 0", o_running); end
  endtask

  task automatic test_load_and_halt();
    for (int i = 0; i < 64; i++) begin
      case (i)
        0:       load_word(8'(i), 32'h2001_0005);
        1:       load_word(8'(i), 32'h2002_0003);
        2:       load_word(8'(i), 32'hFFFF_FFFF);
        default: load_word(8'(i), 32'h0000_0000);
      endcase
    end
    load_word(8'hFF, 32'h0000_0123);
    checks++; if (o_instruction !== 32'h2001_0005) begin errors++; $display("FAIL load_instr0: got %h expected %h", o_instruction, 32'h2001_0005); end
    checks++; if (o_halt !== 1'b0) begin errors++; $display("FAIL load_halt0: got %b expected 0", o_halt); end
    pulse_start();
    checks++; if (o_running !== 1'b1 || o_pc !== 32'h0) begin errors++; $display("FAIL start: got running=%b pc=%h expected running=1 pc=0", o_running, o_pc); end
    tick();
    checks++; if (o_pc !== 32'h4) begin errors++; $display("FAIL run_pc4: got %h expected %h", o_pc, 32'h4); end
    tick();
    checks++; if (o_pc !== 32'h8 || o_halt !== 1'b1) begin errors++; $display("FAIL run_pc8: got pc=%h halt=%b expected pc=8 halt=1", o_pc, o_halt); end
    tick();
    checks++; if (o_running !== 1'b0 || o_pc !== 32'h8) begin errors++; $display("FAIL halted: got running=%b pc=%h expected running=0 pc=8", o_running, o_pc); end
    i_start = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++; if (o_pc !== 32'h8 || o_running !== 1'b0) begin errors++; $display("FAIL halted_hold[%0d]: got pc=%h running=%b expected pc=8 running=0", i, o_pc, o_running); end
    end
    i_start = 1'b0;
  endtask

  task automatic test_idle_write();
    do_reset();
    load_word(8'h00, 32'hA5A5_A5A5);
    checks++; if (o_instruction !== 32'hA5A5_A5A5) begin errors++; $display("FAIL idle_write_visible: got %h expected %h", o_instruction, 32'hA5A5_A5A5); end
    load_word(8'h00, 32'h2001_0005);
    checks++; if (o_instruction !== 32'h2001_0005) begin errors++; $display("FAIL idle_write_restore: got %h expected %h", o_instruction, 32'h2001_0005); end
    i_valid = 1'b0;
    load_word(8'h00, 32'hDEAD_BEEF);
    i_valid = 1'b1;
    checks++; if (o_instruction !== 32'h2001_0005) begin errors++; $display("FAIL invalid_write_dropped: got %h expected %h", o_instruction, 32'h2001_0005); end
  endtask

  task automatic test_stall();
    do_reset();
    load_word(8'h02, 32'h0);
    pulse_start();
    repeat (4) tick();
    checks++; if (o_pc !== 32'h10) begin errors++; $display("FAIL stall_pre: got %h expected %h", o_pc, 32'h10); end
    i_stall = 1'b1;
    tick();
    checks++; if (o_pc !== 32'h10) begin errors++; $display("FAIL stall_1: got %h expected %h", o_pc, 32'h10); end
    tick();
    checks++; if (o_pc !== 32'h10) begin errors++; $display("FAIL stall_2: got %h expected %h", o_pc, 32'h10); end
    i_stall = 1'b0;
    tick();
    checks++; if (o_pc !== 32'h14) begin errors++; $display("FAIL stall_release: got %h expected %h", o_pc, 32'h14); end
    i_valid = 1'b0;
    repeat (2) tick();
    checks++; if (o_pc !== 32'h14) begin errors++; $display("FAIL valid_low_hold: got %h expected %h", o_pc, 32'h14); end
    i_valid = 1'b1;
    tick();
    checks++; if (o_pc !== 32'h18) begin errors++; $display("FAIL valid_resume: got %h expected %h", o_pc, 32'h18); end
  endtask

  task automatic test_jump_branch();
    do_reset();
    pulse_start();
    repeat (3) tick();
    checks++; if (o_pc !== 32'hC) begin errors++; $display("FAIL jb_pre: got %h expected %h", o_pc, 32'hC); end
    i_jump = 1'b1; i_pc_jump = 32'h40;
    i_branch_taken = 1'b1; i_pc_branch = 32'h80;
    tick();
    checks++; if (o_pc !== 32'h80) begin errors++; $display("FAIL branch_priority: got %h expected %h", o_pc, 32'h80); end
    i_branch_taken = 1'b0;
    tick();
    checks++; if (o_pc !== 32'h40) begin errors++; $display("FAIL jump_only: got %h expected %h", o_pc, 32'h40); end
    i_jump = 1'b0;
    tick();
    checks++; if (o_pc !== 32'h44 || o_pc_next !== 32'h48) begin errors++; $display("FAIL after_jump: got pc=%h next=%h expected pc=44 next=48", o_pc, o_pc_next); end
    i_branch_taken = 1'b1; i_pc_branch = 32'hFFFF_FFFC;
    tick();
    i_branch_taken = 1'b0;
    checks++; if (o_pc_next !== 32'h0) begin errors++; $display("FAIL pc_next_wrap: got %h expected %h", o_pc_next, 32'h0); end
    checks++; if (o_instruction !== 32'h0000_0123) begin errors++; $display("FAIL addr_wrap_instr: got %h expected %h", o_instruction, 32'h0000_0123); end
    tick();
    checks++; if (o_pc !== 32'h0) begin errors++; $display("FAIL pc_wrap: got %h expected %h", o_pc, 32'h0); end
  endtask

  task automatic test_step();
    do_reset();
    i_execution_mode = 1'b1;
    pulse_start();
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if (o_pc !== 32'h0 || o_running !== 1'b1) begin errors++; $display("FAIL step_idle[%0d]: got pc=%h running=%b expected pc=0 running=1", i, o_pc, o_running); end
    end
    i_step = 1'b1;
    tick();
    i_step = 1'b0;
    checks++; if (o_pc !== 32'h4) begin errors++; $display("FAIL step_single: got %h expected %h", o_pc, 32'h4); end
    i_step = 1'b1;
    repeat (3) tick();
    i_step = 1'b0;
    checks++; if (o_pc !== 32'h10) begin errors++; $display("FAIL step_held3: got %h expected %h", o_pc, 32'h10); end
    tick();
    checks++; if (o_pc !== 32'h10) begin errors++; $display("FAIL step_released: got %h expected %h", o_pc, 32'h10); end
    i_execution_mode = 1'b0;
  endtask

  task automatic test_halt_stall();
    do_reset();
    load_word(8'h02, 32'hFFFF_FFFF);
    pulse_start();
    repeat (2) tick();
    checks++; if (o_pc !== 32'h8 || o_halt !== 1'b1) begin errors++; $display("FAIL hs_at_halt: got pc=%h halt=%b expected pc=8 halt=1", o_pc, o_halt); end
    i_stall = 1'b1;
    repeat (2) begin
      tick();
      checks++; if (o_pc !== 32'h8 || o_running !== 1'b1) begin errors++; $display("FAIL hs_stalled: got pc=%h running=%b expected pc=8 running=1", o_pc, o_running); end
    end
    i_stall = 1'b0;
    tick();
    checks++; if (o_pc !== 32'h8 || o_running !== 1'b0) begin errors++; $display("FAIL hs_halted: got pc=%h running=%b expected pc=8 running=0", o_pc, o_running); end
  endtask

  task automatic test_run_write_and_reset();
    do_reset();
    load_word(8'h02, 32'h0);
    pulse_start();
    load_word(8'h00, 32'h1234_5678);
    repeat (7) tick();
    checks++; if (o_pc !== 32'h20) begin errors++; $display("FAIL rw_pc20: got %h expected %h", o_pc, 32'h20); end
    i_reset = 1'b1;
    tick();
    i_reset = 1'b0;
    checks++; if (o_running !== 1'b0 || o_pc !== 32'h0 || o_pc_next !== 32'h4) begin errors++; $display("FAIL midrun_reset: got running=%b pc=%h next=%h expected running=0 pc=0 next=4", o_running, o_pc, o_pc_next); end
    checks++; if (o_instruction !== 32'h2001_0005) begin errors++; $display("FAIL run_write_dropped: got %h expected %h", o_instruction, 32'h2001_0005); end
  endtask

  initial begin
    i_reset = 1'b0; i_valid = 1'b0; i_start = 1'b0; i_execution_mode = 1'b0;
    i_step = 1'b0; i_stall = 1'b0; i_jump = 1'b0; i_pc_jump = '0;
    i_branch_taken = 1'b0; i_pc_branch = '0; i_mem_write_enable = 1'b0;
    i_mem_write_addr = '0; i_mem_write_data = '0;
    #2;
    test_reset();
    test_load_and_halt();
    test_idle_write();
    test_stall();
    test_jump_branch();
    test_step();
    test_halt_stall();
    test_run_write_and_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction fetch stage of the 5-stage MIPS pipeline; directly upstream of decode.
- Holds the PC and a debug-loadable instruction memory.
- Supplies decode with instruction, PC+4 and halt indication every enabled cycle.
- Selects the next PC from sequential, jump (from ID), branch (from EX) or stall hold.
- Honours continuous and single-step execution modes.

Parameters:
NB_DATA, 32, data/PC/instruction width
NB_ADDR, 8, instruction memory word-address width (depth = 2^NB_ADDR words)
HALT_INSTRUCTION, 32'hFFFF_FFFF, encoding recognised as halt

Ports:
i_clock  in  1  clock; all state updates on posedge
i_reset  in  1  synchronous, active-high reset
i_valid  in  1  global enable; when low all state holds and memory writes are ignored
i_start  in  1  leave IDLE and begin fetching
i_execution_mode  in  1  0 = continuous, 1 = single-step
i_step  in  1  step pulse; advances one fetch in step mode
i_stall  in  1  hazard stall from decode; hold PC
i_jump  in  1  jump resolved in ID
i_pc_jump  in  NB_DATA  jump target
i_branch_taken  in  1  branch resolved taken in EX
i_pc_branch  in  NB_DATA  branch target
i_mem_write_enable  in  1  program-load write strobe
i_mem_write_addr  in  NB_ADDR  word address for load
i_mem_write_data  in  NB_DATA  instruction word for load
o_instruction  out  NB_DATA  instruction at current PC
o_pc_next  out  NB_DATA  current PC + 4
o_pc  out  NB_DATA  current PC (debug)
o_halt  out  1  current instruction is halt
o_running  out  1  state == RUN

Behaviour:
- States: IDLE, RUN, HALTED. Reset -> IDLE, PC = 0; memory contents are not cleared.
- IDLE -> RUN when i_valid & i_start.
- RUN -> HALTED on an advance where o_halt = 1, i_stall = 0, i_jump = 0 and i_branch_taken = 0.
- HALTED is left only by reset; i_start is ignored in RUN and HALTED.
- advance = i_valid & (state == RUN) & (~i_execution_mode | i_step).
- Next PC on advance, in priority order:
  - i_branch_taken -> i_pc_branch
  - else i_jump -> i_pc_jump
  - else i_stall -> PC held
  - else PC + 4
- If not advancing, PC holds. In HALTED the PC holds at the halt instruction's address.
- Memory read is asynchronous:
  - o_instruction = mem[PC[NB_ADDR+1:2]], zero latency.
  - PC bits [1:0] are ignored.
  - Upper PC bits beyond the depth wrap modulo 2^NB_ADDR.
- o_pc_next = PC + 4, modulo 2^NB_DATA (wraps at 32'hFFFF_FFFC -> 0).
- o_halt = (o_instruction == HALT_INSTRUCTION), combinational. It is valid in every state; decode gates it.
- Program load:
  - Writes occur on posedge when i_valid & i_mem_write_enable & state == IDLE.
  - Writes in RUN or HALTED are dropped.
  - A write to the word currently addressed by the PC is visible on o_instruction the cycle after the edge.
- Wrong-path instructions fetched in the cycle a jump or branch is taken are passed through unchanged; squashing is done downstream via flush.
- In step mode, one posedge with i_step = 1 equals exactly one advance; i_step held for N cycles gives N advances.
- Reset mid-RUN: on the next posedge, state = IDLE and PC = 0; loaded program is retained.
- Reset values of the outputs:
  - o_pc = 0, o_pc_next = 4, o_running = 0.
  - o_instruction = mem[0]; o_halt follows mem[0].

Test Plan:
- Load 0x20010005, 0x20020003, 0xFFFFFFFF at words 0..2; pulse i_start; continuous mode -> o_pc = 0, 4, 8 on successive cycles; o_halt = 1 at PC 8; state HALTED; PC stays 8 for 10 cycles.
- Running at PC 0x10, i_stall = 1 for 2 cycles -> PC stays 0x10 for 2 cycles, then 0x14.
- At PC 0x0C, i_jump = 1 with i_pc_jump = 0x40 and i_branch_taken = 1 with i_pc_branch = 0x80 in the same cycle -> next PC = 0x80 (branch wins). i_jump alone -> next PC = 0x40.
- Step mode at PC 0: i_step low for 5 cycles -> PC stays 0. One i_step pulse -> PC = 4. i_step held 3 cycles -> PC = 0x10.
- Halt at PC 8 coincident with i_stall = 1 -> no transition to HALTED, PC holds. Once i_stall drops -> HALTED.
- Write attempt in RUN to word 0 with 0x12345678 -> mem[0] unchanged. Assert reset at PC 0x20 -> next cycle IDLE, PC = 0, o_instruction = original mem[0], o_running = 0.
